// File: rtl/key_evt_pkg.sv
// Shared types and default timing constants for the key event decoder.
package key_evt_pkg;

    localparam int KEY_CLK_HZ         = 100_000_000;
    localparam int KEY_LONG_CYC_DEF   = KEY_CLK_HZ;
    localparam int KEY_REPEAT_CYC_DEF = KEY_CLK_HZ / 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_e;

endpackage

// File: rtl/key_evt_timer.sv
// Hold-time counter with synchronous clear/enable and a terminal-count flag
// compared against a threshold chosen at run time by the decoder.
module key_evt_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == thresh);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/long/repeat pulses, a held level and a press count.
// Define KEY_EVT_REPEAT_EN to enable auto-repeat pulses while the key stays in the long-press state.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int LONG_CYC   = KEY_LONG_CYC_DEF,
    parameter int REPEAT_CYC = KEY_REPEAT_CYC_DEF,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_lvl,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic       key_rpt,
    output logic       key_held,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

    key_state_e state_q, state_d;
    logic       act_q, act_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       long_q, long_d;
    logic       rpt_q, rpt_d;
    logic       held_q, held_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_tc;
    logic [CNT_W-1:0] tmr_thresh;

    assign act_d      = key_lvl ^ ACTIVE_LOW;
    assign tmr_thresh = (state_q == LONG) ? REPEAT_TC : LONG_TC;

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .thresh (tmr_thresh),
        .tc     (tmr_tc)
    );

    // Release is tested before the threshold so it always wins a same-cycle tie.
    always_comb begin
        state_d     = state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        rpt_d       = 1'b0;
        press_cnt_d = press_cnt_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (act_q) begin
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                    tmr_clr     = 1'b1;
                    state_d     = HELD;
                end
            end
            HELD: begin
                if (!act_q) begin
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = IDLE;
                end else if (tmr_tc) begin
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = LONG;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LONG: begin
                if (!act_q) begin
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = IDLE;
                end else begin
`ifdef KEY_EVT_REPEAT_EN
                    if (tmr_tc) begin
                        rpt_d   = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
`else
                    tmr_clr = 1'b1;
`endif
                end
            end
            default: begin
                tmr_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            rpt_q       <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            rpt_q       <= rpt_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_rpt     = rpt_q;
    assign key_held    = held_q;
    assign press_cnt   = press_cnt_q;

endmodule
